// File: rtl/seg_scan_driver_pkg.sv
// Shared constants for the multiplexed 7-segment scan driver.
// State encodings, the 0-F segment table (bit0=a .. bit6=g) and the blank pattern.
package seg_scan_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Entry 15 first so that SEG_LUT[n] is the pattern for hex digit n.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg_scan_driver_if.sv
// Upstream result-word handshake into the scan driver (valid/ready plus clear).
// master = producer, slave = seg_scan_driver.
interface seg_scan_driver_if #(
  parameter int NDIG = 4
);
  logic                in_valid;
  logic                in_ready;
  logic [4*NDIG-1:0]   in_data;
  logic                in_ovf;
  logic                in_clr;

  modport master (output in_valid, output in_data, output in_ovf, output in_clr, input in_ready);
  modport slave  (input in_valid, input in_data, input in_ovf, input in_clr, output in_ready);
endinterface

// File: rtl/seg_scan_driver_hex_decode.sv
// Combinational hex nibble to 7-segment pattern, active-high, no latency.
module seg_hex_decode
  import seg_scan_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  assign seg = SEG_LUT[hex];
endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed hex display driver: one pending + one display word, digit scan with overflow blink.
// seg/an registered (1 cycle after scan state); in_ready low while a word is pending or clear is asserted.
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int NDIG        = 4,
  parameter int DWELL       = 1024,
  parameter int SEG_ACT_LOW = 0,
  parameter int BLINK_LOG2  = 5
) (
  input  logic              CK,
  input  logic              RN,
  seg_scan_driver_if.slave  bus,
  output logic [6:0]        seg_o,
  output logic              dp_o,
  output logic [NDIG-1:0]   an_o,
  output logic              frame_o
);
  localparam int DW = $clog2(DWELL);
  localparam int IW = $clog2(NDIG);
  localparam int FW = BLINK_LOG2 + 1;
  localparam logic POL = (SEG_ACT_LOW != 0);

  logic [0:0]        state;
  logic              pend_full, pend_ovf, disp_ovf;
  logic [4*NDIG-1:0] pend_data, disp_data;
  logic [DW-1:0]     dwell;
  logic [IW-1:0]     dig;
  logic [FW-1:0]     frame_cnt;
  logic [6:0]        seg_r, seg_dec;
  logic [NDIG-1:0]   an_r, an_nxt;
  logic [3:0]        nib;
  logic              scan, last_dwell, last_dig, frame_end, xfer, accept, blank_ovf;

  assign scan       = (state == ST_SCAN);
  assign last_dwell = (dwell == DW'(DWELL - 1));
  assign last_dig   = (dig == IW'(NDIG - 1));
  assign frame_end  = scan & last_dwell & last_dig;
  // Idle picks up a pending word immediately; scanning only swaps at a frame boundary.
  assign xfer       = ~scan | frame_end;
  assign bus.in_ready = RN & ~pend_full & ~bus.in_clr;
  assign accept     = bus.in_valid & bus.in_ready;
  assign blank_ovf  = disp_ovf & frame_cnt[FW-1];

  always_comb begin
    nib = 4'h0;
    for (int i = 0; i < NDIG; i++) begin
      if (dig == IW'(i)) nib = disp_data[4*i +: 4];
    end
  end

  seg_hex_decode u_dec (.hex(nib), .seg(seg_dec));

  assign an_nxt = (scan & ~blank_ovf) ? (NDIG'(1) << dig) : '0;

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state     <= ST_IDLE;
      pend_full <= 1'b0;
      pend_ovf  <= 1'b0;
      pend_data <= '0;
      disp_ovf  <= 1'b0;
      disp_data <= '0;
      dwell     <= '0;
      dig       <= '0;
      frame_cnt <= '0;
    end else if (bus.in_clr) begin
      state     <= ST_IDLE;
      pend_full <= 1'b0;
      disp_ovf  <= 1'b0;
      disp_data <= '0;
      dwell     <= '0;
      dig       <= '0;
      frame_cnt <= '0;
    end else begin
      if (accept) begin
        pend_data <= bus.in_data;
        pend_ovf  <= bus.in_ovf;
      end
      pend_full <= accept | (pend_full & ~xfer);
      if (scan) begin
        if (frame_end) frame_cnt <= frame_cnt + 1'b1;
        if (last_dwell) begin
          dwell <= '0;
          dig   <= last_dig ? '0 : dig + 1'b1;
        end else begin
          dwell <= dwell + 1'b1;
        end
      end
      if (xfer & pend_full) begin
        disp_data <= pend_data;
        disp_ovf  <= pend_ovf;
        state     <= ST_SCAN;
        dwell     <= '0;
        dig       <= '0;
      end
    end
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      seg_r <= SEG_BLANK;
      an_r  <= '0;
    end else if (bus.in_clr) begin
      seg_r <= SEG_BLANK;
      an_r  <= '0;
    end else begin
      seg_r <= scan ? seg_dec : SEG_BLANK;
      an_r  <= an_nxt;
    end
  end

  assign seg_o   = seg_r ^ {7{POL}};
  assign an_o    = an_r ^ {NDIG{POL}};
  assign dp_o    = POL;
  assign frame_o = frame_end & ~bus.in_clr;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with NDIG=4, DWELL=4, BLINK_LOG2=1, active-high pins.
module tb_seg_scan_driver;
  logic       CK, RN;
  logic [6:0] seg_o;
  logic       dp_o, frame_o;
  logic [3:0] an_o;
  int total = 0;
  int bad   = 0;

  seg_scan_driver_if #(.NDIG(4)) bus ();

  seg_scan_driver #(.NDIG(4), .DWELL(4), .SEG_ACT_LOW(0), .BLINK_LOG2(1)) dut (
    .CK(CK), .RN(RN), .bus(bus), .seg_o(seg_o), .dp_o(dp_o), .an_o(an_o), .frame_o(frame_o)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  logic [3:0] an_exp [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [6:0] seg_1234 [4] = '{7'h66, 7'h4F, 7'h5B, 7'h06};
  logic       found;

  initial begin
    RN = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_ovf = 1'b0; bus.in_clr = 1'b0;
    #2;
    check("rst_rdy", 32'(bus.in_ready), 0);
    check("rst_an", 32'(an_o), 0);
    check("rst_seg", 32'(seg_o), 0);
    check("rst_frame", 32'(frame_o), 0);
    check("rst_dp", 32'(dp_o), 0);
    repeat (3) @(posedge CK);
    @(negedge CK);
    RN = 1'b1;
    #1;
    check("rel_rdy", 32'(bus.in_ready), 1);

    // Word 0x1234: digits scan right to left, 4 cycles each
    tick();
    check("idle_an", 32'(an_o), 0);
    bus.in_valid = 1'b1; bus.in_data = 16'h1234;
    tick();
    bus.in_valid = 1'b0;
    check("t1_rdy_full", 32'(bus.in_ready), 0);
    tick();
    tick();
    for (int d = 0; d < 4; d++) begin
      for (int j = 0; j < 4; j++) begin
        check($sformatf("t1_an_d%0d_%0d", d, j), 32'(an_o), 32'(an_exp[d]));
        check($sformatf("t1_seg_d%0d_%0d", d, j), 32'(seg_o), 32'(seg_1234[d]));
        check($sformatf("t1_frm_d%0d_%0d", d, j), 32'(frame_o), 32'(d == 3 && j == 2));
        tick();
      end
    end
    check("t1_wrap_an", 32'(an_o), 1);
    check("t1_wrap_seg", 32'(seg_o), 32'h66);

    bus.in_clr = 1'b1;
    tick();
    bus.in_clr = 1'b0;
    check("clr1_an", 32'(an_o), 0);

    // Back-to-back words: second waits in pending until the frame boundary
    bus.in_valid = 1'b1; bus.in_data = 16'hAAAA;
    tick();
    bus.in_data = 16'h5555;
    check("t2_rdy_e1", 32'(bus.in_ready), 0);
    tick();
    check("t2_rdy_e2", 32'(bus.in_ready), 1);
    tick();
    check("t2_rdy_e3", 32'(bus.in_ready), 0);
    check("t2_seg_e3", 32'(seg_o), 32'h77);
    bus.in_data = 16'h9999;
    for (int m = 4; m <= 17; m++) begin
      tick();
      check($sformatf("t2_rdy_%0d", m), 32'(bus.in_ready), 0);
      check($sformatf("t2_seg_%0d", m), 32'(seg_o), 32'h77);
      check($sformatf("t2_frm_%0d", m), 32'(frame_o), 32'(m == 17));
    end
    tick();
    check("t2_rdy_e18", 32'(bus.in_ready), 1);
    check("t2_seg_e18", 32'(seg_o), 32'h77);
    tick();
    check("t2_seg_e19", 32'(seg_o), 32'h6D);
    check("t2_an_e19", 32'(an_o), 1);
    check("t2_rdy_e19", 32'(bus.in_ready), 0);
    bus.in_valid = 1'b0;

    // Clear mid-frame with a word pending
    tick();
    tick();
    bus.in_clr = 1'b1;
    #1;
    check("t3_rdy_clr", 32'(bus.in_ready), 0);
    tick();
    check("t3_an", 32'(an_o), 0);
    check("t3_seg", 32'(seg_o), 0);
    bus.in_clr = 1'b0;
    #1;
    check("t3_rdy_after", 32'(bus.in_ready), 1);
    repeat (6) tick();
    check("t3_idle_an", 32'(an_o), 0);

    // Overflow blink: frames 2,3 dark, 0,1,4,5 lit, segments unaffected
    bus.in_valid = 1'b1; bus.in_data = 16'h0F0F; bus.in_ovf = 1'b1;
    tick();
    bus.in_valid = 1'b0; bus.in_ovf = 1'b0;
    tick();
    tick();
    for (int f = 0; f < 6; f++) begin
      for (int c = 0; c < 16; c++) begin
        if (c == 0) begin
          check($sformatf("t4_an_f%0d_d0", f), 32'(an_o), (f == 2 || f == 3) ? 0 : 1);
          check($sformatf("t4_seg_f%0d_d0", f), 32'(seg_o), 32'h71);
        end
        if (c == 4) begin
          check($sformatf("t4_an_f%0d_d1", f), 32'(an_o), (f == 2 || f == 3) ? 0 : 2);
          check($sformatf("t4_seg_f%0d_d1", f), 32'(seg_o), 32'h3F);
        end
        tick();
      end
    end

    // Asynchronous reset in the middle of digit 2
    bus.in_clr = 1'b1;
    tick();
    bus.in_clr = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 16'h1234;
    tick();
    bus.in_valid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      tick();
      if (an_o == 4'b0100) found = 1'b1;
    end
    check("t5_reach_d2", 32'(found), 1);
    check("t5_seg_d2", 32'(seg_o), 32'h5B);
    tick();
    #1;
    RN = 1'b0;
    #1;
    check("t5_an_async", 32'(an_o), 0);
    check("t5_seg_async", 32'(seg_o), 0);
    check("t5_rdy_async", 32'(bus.in_ready), 0);
    #2;
    RN = 1'b1;
    tick();
    check("t5_rdy_rel", 32'(bus.in_ready), 1);
    repeat (8) tick();
    check("t5_idle_an", 32'(an_o), 0);
    check("t5_idle_seg", 32'(seg_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter NDIG, default 4: number of multiplexed digits, legal 2..8.
REQ-002 Parameter DWELL, default 1024: clock cycles each digit stays lit, legal 2..65535.
REQ-003 Parameter SEG_ACT_LOW, default 0: 1 inverts seg_o, dp_o and an_o at the pins.
REQ-004 Parameter BLINK_LOG2, default 5: overflow blink half-period is 2^BLINK_LOG2 frames.
REQ-005 CK  input  1  sole clock; all state on rising edge.
REQ-006 RN  input  1  reset; reset is asynchronous and active-low.
REQ-007 in_valid  input  1  upstream result word valid.
REQ-008 in_ready  output  1  block can accept a word this cycle.
REQ-009 in_data  input  4*NDIG  hex nibbles; nibble 0 (bits 3:0) is the rightmost digit.
REQ-010 in_ovf  input  1  upstream arithmetic overflow flag, qualified by in_valid.
REQ-011 in_clr  input  1  synchronous blank request.
REQ-012 seg_o  output  7  segments, bit0=a .. bit6=g.
REQ-013 dp_o  output  1  decimal point; driven off in this revision.
REQ-014 an_o  output  NDIG  one-hot digit enable.
REQ-015 frame_o  output  1  one-cycle pulse at the end of each complete scan frame.

Function
REQ-016 States: IDLE (nothing shown, an_o all off) and SCAN; no other states.
REQ-017 Holding stages: one pending register (data+ovf+full flag) and one display register (data+ovf).
REQ-018 in_ready SHALL equal NOT pending_full; an accept is in_valid AND in_ready.
REQ-019 An accept loads the pending register and sets pending_full on the same edge.
REQ-020 Transfer point: in IDLE, every cycle; in SCAN, the last dwell cycle of digit NDIG-1.
REQ-021 At a transfer point with pending_full=1, pending moves to display, pending_full clears, state becomes SCAN.
REQ-022 An accept coinciding with a transfer point goes to pending only; it is displayed at the next transfer point.
REQ-023 Scan: dwell counter counts 0..DWELL-1; at DWELL-1 it wraps to 0 and digit index advances, wrapping NDIG-1 to 0.
REQ-024 Entering SCAN resets dwell counter and digit index to 0, so display always starts at digit 0.
REQ-025 In SCAN an_o has exactly one bit set, at the current digit index; seg_o is the hex decode of that nibble.
REQ-026 Hex decode is standard 7-segment 0-F (0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 8=0x7F, A=0x77, F=0x71, bits g..a).
REQ-027 Outputs seg_o and an_o are registered: visible one cycle after the index/counter state that selects them.
REQ-028 frame_o pulses on the cycle digit NDIG-1 dwell wraps; frame counter (BLINK_LOG2+1 bits) increments there, wrapping.
REQ-029 With display ovf=1, an_o is forced all-off while the frame counter MSB is 1; counters keep running.
REQ-030 in_clr=1: next edge clears pending_full, display, frame counter, and forces IDLE; in_clr overrides a same-cycle accept (dropped; in_ready is 0 while in_clr=1).
REQ-031 Pins apply SEG_ACT_LOW inversion after registration; internal logic is polarity-free.

Reset
REQ-032 RN low asynchronously forces IDLE, pending_full=0, display=0, counters=0, frame_o=0, seg_o/an_o/dp_o inactive (all 0 internal).
REQ-033 in_ready SHALL read 0 while RN is low and 1 on the first cycle after release.
REQ-034 Reset mid-frame discards pending and displayed words; no partial frame completes.

Structure
REQ-035 Package seg_scan_pkg holds the state enum, the 16-entry segment lookup constant and the blank pattern.
REQ-036 One sub-module seg_hex_decode (4-bit in, 7-bit out, combinational) SHALL be instantiated once.

Verification (NDIG=4, DWELL=4, BLINK_LOG2=1, SEG_ACT_LOW=0)
REQ-037 Reset, then in_data=0x1234 valid one cycle -> digit 0 shows 0x66 (4) within 3 cycles, an_o=0001 held 4 cycles, then 0x4F/0010, 0x5B/0100, 0x06/1000.
REQ-038 Send 0xAAAA then 0x5555 back-to-back -> second accepted, in_ready=0 after it, 0x5555 appears only after frame_o pulse, third word stalls until then.
REQ-039 in_ovf=1 with 0x0F0F -> an_o all-off for frames 2-3, lit for frames 0-1 and 4-5, seg values unchanged.
REQ-040 in_clr asserted mid-frame with pending full -> next cycle IDLE, an_o=0000, in_ready=1 after in_clr drops.
REQ-041 RN pulled low mid-dwell of digit 2 -> an_o=0000 and seg_o=0 immediately, no clock needed; after release block idles until new word.
